// File: rtl/vec_addsub_pipe_pkg.sv
// ----------------------------------------------------------------------------
// vec_math_pkg
// Shared definitions for the vector math blocks of the ray-tracer pipeline.
//   - OP_ADD / OP_SUB : encoding of the per-transaction op select
//   - DEFAULT_*       : default lane width / lane count for vector math blocks
//   - SAT_W           : internal working width of the sat_add helper
//   - sat_add()       : signed add with overflow detect and optional clamp
// ----------------------------------------------------------------------------
package vec_math_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_LANES      = 3;

    // Working width for sat_add; lane widths up to SAT_W-1 bits are supported.
    localparam int SAT_W = 64;

    // Signed add of two operands already sign-extended to SAT_W bits, both
    // representable in dw bits. Returns {ovf, result}; only result[dw-1:0]
    // is meaningful to the caller. Because the operands are sign-extended
    // well beyond dw, sum[dw] holds the true sign of the exact result, so
    // overflow is simply sum[dw] != sum[dw-1].
    function automatic logic [SAT_W:0] sat_add(
        input logic [SAT_W-1:0] a,
        input logic [SAT_W-1:0] b,
        input int unsigned      dw,
        input logic             saturate
    );
        logic [SAT_W-1:0] sum;
        logic [SAT_W-1:0] sum_hi;
        logic [SAT_W-1:0] sum_lo;
        logic [SAT_W-1:0] max_v;
        logic [SAT_W-1:0] min_v;
        logic [SAT_W-1:0] res;
        logic             ovf;

        sum    = a + b;
        // Shifts instead of variable bit-selects keep index widths clean.
        sum_hi = sum >> dw;
        sum_lo = sum >> (dw - 32'd1);
        ovf    = sum_hi[0] ^ sum_lo[0];
        max_v  = (SAT_W'(1) << (dw - 32'd1)) - SAT_W'(1);
        min_v  = ~max_v;

        if (saturate && ovf) begin
            res = sum_hi[0] ? min_v : max_v;
        end else begin
            res = sum;
        end
        return {ovf, res};
    endfunction

endpackage

// File: rtl/vec_addsub_pipe_if.sv
// ----------------------------------------------------------------------------
// vec_addsub_pipe_if
// Bus bundle of vec_addsub_pipe.
//   Input side (FWFT upstream FIFO): x, y, op_sub, in_empty -> in_rd_en
//   Output side (FWFT result buffer): out, out_ovf, out_empty, out_count
//                                     <- out_rd_en
// Lanes are packed, lane 0 in the least significant DATA_WIDTH bits.
// Modports:
//   slave  - the vec_addsub_pipe view
//   master - the environment view (upstream FIFO + downstream consumer)
// ----------------------------------------------------------------------------
interface vec_addsub_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int LANES      = 3,
    parameter int OUT_DEPTH  = 16
);
    logic [LANES-1:0][DATA_WIDTH-1:0] x;
    logic [LANES-1:0][DATA_WIDTH-1:0] y;
    logic                             op_sub;
    logic                             in_empty;
    logic                             in_rd_en;
    logic [LANES-1:0][DATA_WIDTH-1:0] out;
    logic [LANES-1:0]                 out_ovf;
    logic                             out_empty;
    logic                             out_rd_en;
    logic [$clog2(OUT_DEPTH):0]       out_count;

    modport slave (
        input  x, y, op_sub, in_empty, out_rd_en,
        output in_rd_en, out, out_ovf, out_empty, out_count
    );

    modport master (
        output x, y, op_sub, in_empty, out_rd_en,
        input  in_rd_en, out, out_ovf, out_empty, out_count
    );
endinterface

// File: rtl/vec_addsub_lane.sv
// ----------------------------------------------------------------------------
// vec_addsub_lane
// Combinational single-lane signed add/subtract with overflow flag.
//   x, y    in  DATA_WIDTH  signed operands
//   op_sub  in  1           OP_ADD: x+y, OP_SUB: x-y
//   result  out DATA_WIDTH  clamped (SATURATE=1) or wrapped (SATURATE=0)
//   ovf     out 1           exact result did not fit in DATA_WIDTH bits
// ----------------------------------------------------------------------------
module vec_addsub_lane
    import vec_math_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int SATURATE   = 1
) (
    input  logic [DATA_WIDTH-1:0] x,
    input  logic [DATA_WIDTH-1:0] y,
    input  logic                  op_sub,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  ovf
);

    logic [SAT_W-1:0]          x_ext_s;
    logic [SAT_W-1:0]          y_ext_s;
    logic [SAT_W-1:0]          b_ext_s;
    logic [SAT_W:0]            sum_s;
    logic [SAT_W-1:DATA_WIDTH] lane_unused_s;

    // Sign-extend, negate y for subtract (safe: the extension leaves headroom
    // for -(min)), then add with overflow handling.
    always_comb begin
        x_ext_s = {{(SAT_W-DATA_WIDTH){x[DATA_WIDTH-1]}}, x};
        y_ext_s = {{(SAT_W-DATA_WIDTH){y[DATA_WIDTH-1]}}, y};
        if (op_sub == OP_SUB) begin
            b_ext_s = SAT_W'(0) - y_ext_s;
        end else begin
            b_ext_s = y_ext_s;
        end
        sum_s         = sat_add(x_ext_s, b_ext_s, DATA_WIDTH, (SATURATE != 0));
        result        = sum_s[DATA_WIDTH-1:0];
        ovf           = sum_s[SAT_W];
        lane_unused_s = sum_s[SAT_W-1:DATA_WIDTH];
    end

endmodule

// File: rtl/vec_addsub_pipe.sv
// ----------------------------------------------------------------------------
// vec_addsub_pipe
// N-lane signed vector add/subtract, one vector per cycle.
//   clock   in  rising-edge clock
//   reset   in  synchronous active-high reset; drops staged and buffered data
//   bus     vec_addsub_pipe_if.slave
//     x, y, op_sub, in_empty -> in_rd_en   : pops the upstream FWFT FIFO
//     out, out_ovf, out_empty, out_count   : FWFT result buffer head/state
//     out_rd_en                            : pops the result buffer
// Flow: operands popped at edge E0 land (as results) in the stage register,
// and the stage is written into the circular buffer at E1. Input pops are
// gated by credit: buffered entries plus the staged entry must stay below
// OUT_DEPTH, so the E1 write always has room. A read in the same cycle is
// not credited until the next cycle.
// ----------------------------------------------------------------------------
module vec_addsub_pipe
    import vec_math_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int LANES      = DEFAULT_LANES,
    parameter int OUT_DEPTH  = 16,
    parameter int SATURATE   = 1
) (
    input  logic               clock,
    input  logic               reset,
    vec_addsub_pipe_if.slave   bus
);

    localparam int PW = $clog2(OUT_DEPTH);
    localparam int CW = PW + 1;

    typedef logic [LANES-1:0][DATA_WIDTH-1:0] vec_t;

    // Per-lane arithmetic
    vec_t             lane_res_s;
    logic [LANES-1:0] lane_ovf_s;

    // Stage register
    logic             stage_valid_r;
    vec_t             stage_data_r;
    logic [LANES-1:0] stage_ovf_r;

    // Circular buffer
    vec_t             mem_data_r [OUT_DEPTH];
    logic [LANES-1:0] mem_ovf_r  [OUT_DEPTH];
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;

    // Registered head view
    vec_t             out_data_r;
    logic [LANES-1:0] out_ovf_r;
    logic             out_empty_r;

    // Control
    logic [CW:0]      occupancy_s;
    logic             in_rd_en_s;
    logic             wr_fire_s;
    logic             rd_fire_s;
    logic [CW-1:0]    count_next_s;
    logic [PW-1:0]    rd_ptr_next_s;
    vec_t             head_data_s;
    logic [LANES-1:0] head_ovf_s;

    genvar g;
    generate
        for (g = 0; g < LANES; g++) begin : g_lane
            vec_addsub_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .SATURATE   (SATURATE)
            ) u_lane (
                .x      (bus.x[g]),
                .y      (bus.y[g]),
                .op_sub (bus.op_sub),
                .result (lane_res_s[g]),
                .ovf    (lane_ovf_s[g])
            );
        end
    endgenerate

    // Credit check, fire strobes, next count/pointer and next head selection.
    always_comb begin
        occupancy_s = {1'b0, count_r} + (CW+1)'(stage_valid_r);
        in_rd_en_s  = !bus.in_empty && (occupancy_s < (CW+1)'(OUT_DEPTH));
        wr_fire_s   = stage_valid_r;
        rd_fire_s   = bus.out_rd_en && (count_r != CW'(0));

        case ({wr_fire_s, rd_fire_s})
            2'b10:   count_next_s = count_r + CW'(1);
            2'b01:   count_next_s = count_r - CW'(1);
            default: count_next_s = count_r;
        endcase

        if (rd_fire_s) begin
            rd_ptr_next_s = rd_ptr_r + PW'(1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end

        // The entry that becomes head may be the one being written this
        // edge (buffer empty or drained to it), so bypass the stage data.
        if (wr_fire_s && (rd_ptr_next_s == wr_ptr_r)) begin
            head_data_s = stage_data_r;
            head_ovf_s  = stage_ovf_r;
        end else begin
            head_data_s = mem_data_r[rd_ptr_next_s];
            head_ovf_s  = mem_ovf_r[rd_ptr_next_s];
        end
    end

    // Stage register, pointers, count and registered head view.
    always_ff @(posedge clock) begin
        if (reset) begin
            stage_valid_r <= 1'b0;
            stage_data_r  <= '0;
            stage_ovf_r   <= '0;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            count_r       <= '0;
            out_data_r    <= '0;
            out_ovf_r     <= '0;
            out_empty_r   <= 1'b1;
        end else begin
            stage_valid_r <= in_rd_en_s;
            if (in_rd_en_s) begin
                stage_data_r <= lane_res_s;
                stage_ovf_r  <= lane_ovf_s;
            end
            if (wr_fire_s) begin
                wr_ptr_r <= wr_ptr_r + PW'(1);
            end
            rd_ptr_r    <= rd_ptr_next_s;
            count_r     <= count_next_s;
            out_empty_r <= (count_next_s == CW'(0));
            // Hold the last head when the buffer drains.
            if (count_next_s != CW'(0)) begin
                out_data_r <= head_data_s;
                out_ovf_r  <= head_ovf_s;
            end
        end
    end

    // Buffer storage; no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clock) begin
        if (!reset && wr_fire_s) begin
            mem_data_r[wr_ptr_r] <= stage_data_r;
            mem_ovf_r[wr_ptr_r]  <= stage_ovf_r;
        end
    end

    assign bus.in_rd_en  = in_rd_en_s;
    assign bus.out       = out_data_r;
    assign bus.out_ovf   = out_ovf_r;
    assign bus.out_empty = out_empty_r;
    assign bus.out_count = count_r;

endmodule

// File: tb/tb_vec_addsub_pipe.sv
// ----------------------------------------------------------------------------
// tb_vec_addsub_pipe
// Directed bench for vec_addsub_pipe. dut (SATURATE=1) is the main target;
// dut_wrap (SATURATE=0) sees the same inputs and is checked on the
// subtract-overflow vector.
// ----------------------------------------------------------------------------
module tb_vec_addsub_pipe;
    import vec_math_pkg::*;

    localparam int DW = 32;
    localparam int LN = 3;
    localparam int OD = 16;

    typedef logic [LN-1:0][DW-1:0] vec_t;

    logic clock = 1'b0;
    logic reset;

    always #5 clock = ~clock;

    vec_addsub_pipe_if #(.DATA_WIDTH(DW), .LANES(LN), .OUT_DEPTH(OD)) bus_s ();
    vec_addsub_pipe_if #(.DATA_WIDTH(DW), .LANES(LN), .OUT_DEPTH(OD)) bus_w ();

    vec_addsub_pipe #(.DATA_WIDTH(DW), .LANES(LN), .OUT_DEPTH(OD), .SATURATE(1)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_s.slave)
    );

    vec_addsub_pipe #(.DATA_WIDTH(DW), .LANES(LN), .OUT_DEPTH(OD), .SATURATE(0)) dut_wrap (
        .clock (clock),
        .reset (reset),
        .bus   (bus_w.slave)
    );

    assign bus_w.x         = bus_s.x;
    assign bus_w.y         = bus_s.y;
    assign bus_w.op_sub    = bus_s.op_sub;
    assign bus_w.in_empty  = bus_s.in_empty;
    assign bus_w.out_rd_en = bus_s.out_rd_en;

    int n_applied = 0;
    int n_miss    = 0;
    int nxt;
    int rd_idx;
    int max_cnt;
    int cyc;

    // Count one comparison and report it when it does not match.
    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_applied++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic vec_t mk(input int a, input int b, input int c);
        vec_t v;
        v[0] = a;
        v[1] = b;
        v[2] = c;
        return v;
    endfunction

    // Stream vector i: x={i,1000+i,-i}, y={3i,7,i}, odd i subtract.
    function automatic vec_t src_x(input int i);
        return mk(i, 1000 + i, -i);
    endfunction

    function automatic vec_t src_y(input int i);
        return mk(3 * i, 7, i);
    endfunction

    function automatic vec_t exp_r(input int i);
        if (i % 2 == 1) begin
            return mk(-2 * i, 993 + i, -2 * i);
        end
        return mk(4 * i, 1007 + i, 0);
    endfunction

    // One cycle of the upstream FIFO model + consumer scoreboard.
    task automatic stream_cycle(input int total, input bit chk_flow);
        logic rd;
        bus_s.in_empty = (nxt >= total);
        bus_s.x        = src_x(nxt);
        bus_s.y        = src_y(nxt);
        bus_s.op_sub   = (nxt % 2 == 1) ? OP_SUB : OP_ADD;
        #1;
        rd = bus_s.in_rd_en;
        if (chk_flow && nxt < total) begin
            check_val("flow in_rd_en", rd, 1'b1);
        end
        if (chk_flow) begin
            check_val("flow count_le2", (bus_s.out_count <= 5'd2), 1'b1);
        end
        if (bus_s.out_rd_en && !bus_s.out_empty) begin
            check_val($sformatf("stream data %0d", rd_idx), bus_s.out, exp_r(rd_idx));
            rd_idx++;
        end
        if (int'(bus_s.out_count) > max_cnt) begin
            max_cnt = int'(bus_s.out_count);
        end
        @(posedge clock);
        #1;
        if (rd) begin
            nxt++;
        end
    endtask

    initial begin
        reset           = 1'b1;
        bus_s.in_empty  = 1'b1;
        bus_s.out_rd_en = 1'b0;
        bus_s.op_sub    = OP_ADD;
        bus_s.x         = '0;
        bus_s.y         = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // Reset state and idle
        check_val("reset out", bus_s.out, '0);
        check_val("reset ovf", bus_s.out_ovf, 3'b000);
        for (int i = 0; i < 10; i++) begin
            check_val("idle in_rd_en", bus_s.in_rd_en, 1'b0);
            check_val("idle out_empty", bus_s.out_empty, 1'b1);
            check_val("idle out_count", bus_s.out_count, 5'd0);
            @(posedge clock);
            #1;
        end

        // Single add with lane-2 positive overflow
        bus_s.x        = mk(1, -2, 32'h7FFF0000);
        bus_s.y        = mk(2, 5, 32'h00010000);
        bus_s.op_sub   = OP_ADD;
        bus_s.in_empty = 1'b0;
        #1;
        check_val("add in_rd_en", bus_s.in_rd_en, 1'b1);
        @(posedge clock);
        #1;
        bus_s.in_empty = 1'b1;
        check_val("add latency N+1 empty", bus_s.out_empty, 1'b1);
        @(posedge clock);
        #1;
        check_val("add latency N+2 ready", bus_s.out_empty, 1'b0);
        check_val("add data", bus_s.out, mk(3, 3, 32'h7FFFFFFF));
        check_val("add ovf", bus_s.out_ovf, 3'b100);
        check_val("add count", bus_s.out_count, 5'd1);
        bus_s.out_rd_en = 1'b1;
        @(posedge clock);
        #1;
        bus_s.out_rd_en = 1'b0;
        check_val("add drained", bus_s.out_empty, 1'b1);
        check_val("add count0", bus_s.out_count, 5'd0);
        check_val("add hold", bus_s.out, mk(3, 3, 32'h7FFFFFFF));
        // Read while empty is ignored
        bus_s.out_rd_en = 1'b1;
        @(posedge clock);
        #1;
        bus_s.out_rd_en = 1'b0;
        check_val("empty read count", bus_s.out_count, 5'd0);

        // Subtract with lane-0 negative overflow, both saturation modes
        bus_s.x        = mk(32'h80000000, 10, 0);
        bus_s.y        = mk(1, 3, -7);
        bus_s.op_sub   = OP_SUB;
        bus_s.in_empty = 1'b0;
        @(posedge clock);
        #1;
        bus_s.in_empty = 1'b1;
        @(posedge clock);
        #1;
        check_val("sub sat data", bus_s.out, mk(32'h80000000, 7, 7));
        check_val("sub sat ovf", bus_s.out_ovf, 3'b001);
        check_val("sub wrap data", bus_w.out, mk(32'h7FFFFFFF, 7, 7));
        check_val("sub wrap ovf", bus_w.out_ovf, 3'b001);
        bus_s.out_rd_en = 1'b1;
        @(posedge clock);
        #1;
        bus_s.out_rd_en = 1'b0;

        // Fill to capacity with no reads, then drain in order
        nxt     = 0;
        rd_idx  = 0;
        max_cnt = 0;
        repeat (30) stream_cycle(40, 1'b0);
        check_val("fill accepted", nxt, 16);
        check_val("fill count", bus_s.out_count, 5'd16);
        bus_s.in_empty = 1'b0;
        #1;
        check_val("fill in_rd_en", bus_s.in_rd_en, 1'b0);
        bus_s.out_rd_en = 1'b1;
        cyc = 0;
        while (rd_idx < 40 && cyc < 300) begin
            stream_cycle(40, 1'b0);
            cyc++;
        end
        check_val("drain all out", rd_idx, 40);
        check_val("drain all in", nxt, 40);
        check_val("drain max count", max_cnt, 16);

        // Continuous input and read: one result per cycle
        nxt     = 0;
        rd_idx  = 0;
        max_cnt = 0;
        cyc     = 0;
        while (rd_idx < 30 && cyc < 200) begin
            stream_cycle(30, 1'b1);
            cyc++;
        end
        check_val("flow cycles", cyc, 32);
        check_val("flow max count", (max_cnt <= 2), 1'b1);
        bus_s.out_rd_en = 1'b0;

        // Reset with 5 buffered entries and a valid stage
        nxt = 0;
        repeat (6) stream_cycle(6, 1'b0);
        check_val("pre-reset count", bus_s.out_count, 5'd5);
        bus_s.in_empty = 1'b1;
        reset          = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        check_val("mid reset empty", bus_s.out_empty, 1'b1);
        check_val("mid reset count", bus_s.out_count, 5'd0);
        check_val("mid reset out", bus_s.out, '0);
        @(posedge clock);
        #1;
        check_val("no stale write", bus_s.out_count, 5'd0);
        bus_s.x        = mk(4, 4, 4);
        bus_s.y        = mk(1, 1, 1);
        bus_s.op_sub   = OP_ADD;
        bus_s.in_empty = 1'b0;
        @(posedge clock);
        #1;
        bus_s.in_empty = 1'b1;
        cyc = 0;
        while (bus_s.out_empty && cyc < 10) begin
            @(posedge clock);
            #1;
            cyc++;
        end
        check_val("post reset data", bus_s.out, mk(5, 5, 5));
        check_val("post reset ovf", bus_s.out_ovf, 3'b000);
        check_val("post reset count", bus_s.out_count, 5'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
        $finish;
    end

endmodule
